lb_2_glb_mc: RTL
================

LB_2_GLB_MC -- requirements
Module: lb_2_glb_mc

Interface
REQ-001 Parameter DATA_W, 128, width of one tile pixel word and of the write data.
REQ-002 Parameter ADDR_W, 16, global-buffer word address width.
REQ-003 Parameter DIM_W, 5, width of the tile length and tile height fields.
REQ-004 Parameter CH_W, 3, width of the channel-count field (up to 2^CH_W-1 channels).
REQ-005 Port clock, in, 1, single clock; all logic on the rising edge.
REQ-006 Port rst, in, 1, reset; synchronous and active-high.
REQ-007 Port cfg_start, in, 1, one-cycle request to latch the configuration and begin a transfer.
REQ-008 Port of_base_addr, in, ADDR_W, first word address of channel 0.
REQ-009 Port of_page_length, in, ADDR_W, address step between tile rows.
REQ-010 Port of_ch_stride, in, ADDR_W, address step between channels.
REQ-011 Ports of_tile_length and of_tile_height, in, DIM_W each, words per row and rows per channel.
REQ-012 Port of_ch_num, in, CH_W, number of channels.
REQ-013 Ports pix_valid (in, 1), pix_data (in, DATA_W) and pix_ready (out, 1), input pixel stream handshake.
REQ-014 Ports wr_en (out, 1), wr_addr (out, ADDR_W), wr_data (out, DATA_W) and wr_ready (in, 1), global-buffer write handshake.
REQ-015 Ports busy (out, 1), done (out, 1) and cfg_err (out, 1), status outputs.

Function
REQ-016 States SHALL be IDLE, RUN and DONE; busy SHALL be 1 exactly in RUN and DONE.
REQ-017 IDLE: on cfg_start=1 all of_* inputs SHALL be registered.
  - Any of of_tile_length, of_tile_height or of_ch_num equal to 0: cfg_err SHALL pulse for 1 cycle and the state SHALL stay IDLE.
  - Otherwise the state SHALL go to RUN and counters h, v and ch SHALL clear to 0.
REQ-018 cfg_start SHALL be ignored outside IDLE; configuration inputs may change freely after latching without effect.
REQ-019 A pixel beat SHALL be accepted on a cycle with pix_valid=1 and pix_ready=1.
REQ-020 pix_ready SHALL be 1 only in RUN, while unaccepted beats remain, and when (wr_en=0 or wr_ready=1).
  - pix_ready SHALL have no combinational dependence on pix_valid.
REQ-021 An accepted beat SHALL produce, on the next cycle, wr_en=1, wr_data=that beat's pix_data, and wr_addr=(base + ch*ch_stride + v*page_length + h) mod 2^ADDR_W.
  - All products are computed at full width and truncated only on the final sum.
REQ-022 While wr_en=1 and wr_ready=0, wr_en, wr_addr and wr_data SHALL hold stable.
REQ-023 wr_en SHALL fall on the cycle after a write is taken (wr_en=1 and wr_ready=1) unless a new beat is accepted in that same cycle.
  - With continuous valid/ready, throughput SHALL be 1 word per cycle.
REQ-024 Counter order SHALL be h innermost, then v, then ch.
  - h wraps at tile_length-1 (incrementing v).
  - v wraps at tile_height-1 (incrementing ch).
  - The beat at h=L-1, v=H-1, ch=N-1 SHALL be marked last.
REQ-025 After the last beat is accepted, pix_ready SHALL stay 0.
  - When the last write is taken, the state SHALL go to DONE.
REQ-026 DONE: done SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE; a cfg_start during DONE SHALL be ignored.
REQ-027 Total writes per transfer SHALL equal L*H*N, each issued exactly once, with no duplicates or gaps.
REQ-028 wr_addr and wr_data SHALL read 0 whenever wr_en=0.

Reset
REQ-029 On rst=1 at a clock edge, the state SHALL become IDLE; h, v, ch and all latched configuration SHALL clear.
  - wr_en, wr_addr, wr_data, pix_ready, busy, done and cfg_err SHALL be 0 on the following cycle.
REQ-030 A reset mid-transfer SHALL abandon the transfer without a done pulse; any pending write SHALL be dropped (wr_en=0).
REQ-031 rst SHALL take priority over cfg_start in the same cycle.

Verification
REQ-032 Single-channel transfer: base=0x0100, page=0x0020, L=4, H=2, N=1, valid held high, wr_ready=1.
  - Expected addresses 0x100-0x103 then 0x120-0x123, on 8 consecutive cycles starting 1 cycle after the first accept.
  - done SHALL pulse 1 cycle after the last write.
REQ-033 Multi-channel transfer: base=0, page=8, stride=0x40, L=2, H=2, N=3.
  - Expected 12 writes, with channel 2 starting at 0x80 and the last write at 0x89.
REQ-034 Backpressure: wr_ready=0 for 3 cycles at the 2nd write.
  - wr_en, wr_addr and wr_data SHALL hold; pix_ready=0 during the stall.
  - No beat SHALL be lost, and the write count SHALL stay L*H*N.
REQ-035 Address wraparound: base=0xFFFE, page=0x10, L=4, H=1, N=1.
  - Expected addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-036 Zero dimension: cfg_start with L=0.
  - cfg_err SHALL pulse 1 cycle; busy SHALL stay 0; no writes.
  - A following valid cfg_start SHALL run normally.
REQ-037 Reset mid-transfer: rst=1 after 3 of 8 writes.
  - The next cycle SHALL show all outputs 0 and no done pulse.
  - A fresh transfer SHALL start at h=v=ch=0.

Source files
------------

// File: rtl/lb_2_glb_mc.sv
// Line-buffer to global-buffer write master: walks an L x H x N tile in
// h/v/ch order and issues one addressed write per accepted pixel beat.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for cfg_start; latches configuration, checks dimensions
// RUN   | accepting pixel beats and issuing global-buffer writes
// DONE  | one-cycle completion pulse, then back to IDLE
module lb_2_glb_mc #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 5,
    parameter int CH_W   = 3
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] of_base_addr,
    input  logic [ADDR_W-1:0] of_page_length,
    input  logic [ADDR_W-1:0] of_ch_stride,
    input  logic [DIM_W-1:0]  of_tile_length,
    input  logic [DIM_W-1:0]  of_tile_height,
    input  logic [CH_W-1:0]   of_ch_num,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, page_q, stride_q;
    logic [DIM_W-1:0]  len_q, hgt_q, h_q, v_q;
    logic [CH_W-1:0]   chn_q, ch_q;
    logic              last_acc_q;
    logic              cfg_err_q;

    logic              cfg_ok, h_end, v_end, ch_end, last_beat;
    logic              write_taken, accept;
    logic [ADDR_W-1:0] addr_next;

    assign cfg_ok      = (of_tile_length != '0) && (of_tile_height != '0) && (of_ch_num != '0);
    assign h_end       = (h_q == len_q - DIM_W'(1));
    assign v_end       = (v_q == hgt_q - DIM_W'(1));
    assign ch_end      = (ch_q == chn_q - CH_W'(1));
    assign last_beat   = h_end && v_end && ch_end;
    assign write_taken = wr_en && wr_ready;
    assign pix_ready   = (state_q == RUN) && !last_acc_q && (!wr_en || wr_ready);
    assign accept      = pix_valid && pix_ready;

    // Modular sum: truncating each product to ADDR_W yields the same low bits
    // as a full-width sum truncated at the end.
    assign addr_next = base_q + ADDR_W'(ch_q) * stride_q + ADDR_W'(v_q) * page_q + ADDR_W'(h_q);

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign cfg_err = cfg_err_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_start && cfg_ok) state_d = RUN;
            RUN:     if (last_acc_q && write_taken) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            base_q     <= '0;
            page_q     <= '0;
            stride_q   <= '0;
            len_q      <= '0;
            hgt_q      <= '0;
            chn_q      <= '0;
            h_q        <= '0;
            v_q        <= '0;
            ch_q       <= '0;
            last_acc_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            cfg_err_q <= 1'b0;
            if (state_q == IDLE && cfg_start) begin
                base_q     <= of_base_addr;
                page_q     <= of_page_length;
                stride_q   <= of_ch_stride;
                len_q      <= of_tile_length;
                hgt_q      <= of_tile_height;
                chn_q      <= of_ch_num;
                h_q        <= '0;
                v_q        <= '0;
                ch_q       <= '0;
                last_acc_q <= 1'b0;
                cfg_err_q  <= !cfg_ok;
            end
            if (accept) begin
                wr_en   <= 1'b1;
                wr_addr <= addr_next;
                wr_data <= pix_data;
                if (last_beat) last_acc_q <= 1'b1;
                if (h_end) begin
                    h_q <= '0;
                    if (v_end) begin
                        v_q  <= '0;
                        ch_q <= ch_q + CH_W'(1);
                    end else begin
                        v_q <= v_q + DIM_W'(1);
                    end
                end else begin
                    h_q <= h_q + DIM_W'(1);
                end
            end else if (write_taken) begin
                wr_en   <= 1'b0;
                wr_addr <= '0;
                wr_data <= '0;
            end
        end
    end

endmodule
